// File: rtl/code_entry_checker.sv
// rtl/code_entry_checker.sv - keypad code entry, compare, lockout and reprogramming front end
module code_entry_checker #(
    parameter int             DIGITS       = 4,
    parameter int             TIMEOUT_CYC  = 50_000_000,
    parameter logic [DIGITS*4-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       prog_req,
    input  logic       lockout,
    output logic       err_pulse,
    output logic       ok_pulse,
    output logic       unlocked,
    output logic [2:0] digit_cnt,
    output logic       prog_done
);

    localparam int BW = DIGITS * 4;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    CNT_FULL   = 3'(DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_PROG     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [BW-1:0]   code_q, code_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            ok_q, ok_d;
    logic            done_q, done_d;

    logic            digit_ok;
    logic            timed_out;
    logic            count_ok;
    logic [BW-1:0]   buf_shift;

    // Decode of the incoming digit and of the entry-complete conditions.
    always_comb begin
        digit_ok  = key_valid && (key_digit <= 4'd9);
        timed_out = (timer_q == TIMER_LAST);
        count_ok  = (cnt_q == CNT_FULL) && !ovf_q;
        buf_shift = {buf_q[BW-5:0], key_digit};
    end

    // Next-state and pulse logic. Strobes that have no effect in the current
    // state do not mask lower-priority strobes; among effective ones the order
    // is clear, enter, digit, prog_req.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        timer_d = timer_q;
        err_d   = 1'b0;
        ok_d    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (lockout) begin
                    buf_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (digit_ok) begin
                    buf_d   = buf_shift;
                    cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 3'd1;
                    ovf_d   = ovf_q | (cnt_q == CNT_FULL);
                    state_d = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (lockout || key_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (key_enter) begin
                    if (count_ok && (buf_q == code_q)) begin
                        ok_d    = 1'b1;
                        state_d = ST_UNLOCKED;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = '0;
                end else if (digit_ok) begin
                    buf_d   = buf_shift;
                    cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 3'd1;
                    ovf_d   = ovf_q | (cnt_q == CNT_FULL);
                    timer_d = '0;
                end else if (timed_out) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_UNLOCKED: begin
                timer_d = '0;
                if (key_enter) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (prog_req) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_PROG;
                end
            end

            ST_PROG: begin
                if (key_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = '0;
                    state_d = ST_UNLOCKED;
                end else if (key_enter) begin
                    if (count_ok) begin
                        code_d = buf_q;
                        done_d = 1'b1;
                    end
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = '0;
                    state_d = ST_UNLOCKED;
                end else if (digit_ok) begin
                    buf_d   = buf_shift;
                    cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 3'd1;
                    ovf_d   = ovf_q | (cnt_q == CNT_FULL);
                    timer_d = '0;
                end else if (timed_out) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = '0;
                    state_d = ST_UNLOCKED;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                buf_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, entry buffer, stored code and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            code_q  <= DEFAULT_CODE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            timer_q <= '0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
        end
    end

    // Outputs are taken straight from flops so the downstream edge detector
    // never sees a glitch.
    always_comb begin
        err_pulse = err_q;
        ok_pulse  = ok_q;
        prog_done = done_q;
        digit_cnt = cnt_q;
        unlocked  = (state_q == ST_UNLOCKED) || (state_q == ST_PROG);
    end

endmodule
